uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_tx_if.sv | 35 +++
 rtl/uart_baud_counter.sv | 32 +++
 rtl/uart_tx.sv | 152 +++++++++++++++
 tb/tb_uart_tx.sv | 367 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry and transmitter state encoding.
// Kept separate so the receiver can use the same constants.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
  localparam int DIV_W     = 16;

  typedef logic [2:0] tx_state_t;

  localparam tx_state_t ST_IDLE   = 3'd0;
  localparam tx_state_t ST_START  = 3'd1;
  localparam tx_state_t ST_DATA   = 3'd2;
  localparam tx_state_t ST_PARITY = 3'd3;
  localparam tx_state_t ST_STOP   = 3'd4;

endpackage

// File: rtl/uart_tx_if.sv
// Transmitter request/line bundle; slave is the transmitter, master the client.
interface uart_tx_if import uart_pkg::*; ();

  logic                 start_i;
  logic [DATA_BITS-1:0] data_i;
  logic                 parity_bit_i;
  logic                 parity_even_i;
  logic [DIV_W-1:0]     clock_divider_i;
  logic                 serial_o;
  logic                 busy_o;
  logic                 done_o;

  modport slave (
    input  start_i,
    input  data_i,
    input  parity_bit_i,
    input  parity_even_i,
    input  clock_divider_i,
    output serial_o,
    output busy_o,
    output done_o
  );

  modport master (
    output start_i,
    output data_i,
    output parity_bit_i,
    output parity_even_i,
    output clock_divider_i,
    input  serial_o,
    input  busy_o,
    input  done_o
  );

endinterface

// File: rtl/uart_baud_counter.sv
// Bit-period counter: counts 0..D-1 and strobes on the last cycle of each bit.
// A divider of 0 behaves as 1, so the strobe then fires every cycle.
module uart_baud_counter import uart_pkg::*; (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic [DIV_W-1:0] divider_i,
  input  logic             restart_i,
  output logic             bit_end_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] last_cnt;

  assign last_cnt  = (divider_i == '0) ? '0 : divider_i - 1'b1;
  assign bit_end_o = (cnt_q == last_cnt);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart_i || bit_end_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 with optional parity, all outputs registered.
// States: IDLE wait | START low | DATA LSB first | PARITY | STOP high, then done pulse.
module uart_tx import uart_pkg::*; (
  input  logic clock_i,
  input  logic reset_i,
  uart_tx_if.slave tx_if
);

  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [1:0]           stop_idx_q, stop_idx_d;
  logic                 par_en_q, par_en_d;
  logic                 par_even_q, par_even_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic                 serial_q, serial_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 bit_end;
  logic                 restart;
  logic                 parity;
  logic [2:0]           next_idx;

  // The counter is held at zero while idle so the start bit gets a full period.
  assign restart  = (state_q == ST_IDLE);
  assign parity   = par_even_q ? ^data_q : ~^data_q;
  assign next_idx = bit_idx_q + 3'd1;

  uart_baud_counter u_baud (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .divider_i (div_q),
    .restart_i (restart),
    .bit_end_o (bit_end)
  );

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    par_en_d   = par_en_q;
    par_even_d = par_even_q;
    div_d      = div_q;
    serial_d   = serial_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        serial_d = 1'b1;
        busy_d   = 1'b0;
        if (tx_if.start_i) begin
          data_d     = tx_if.data_i;
          par_en_d   = tx_if.parity_bit_i;
          par_even_d = tx_if.parity_even_i;
          div_d      = tx_if.clock_divider_i;
          bit_idx_d  = 3'd0;
          stop_idx_d = 2'd0;
          serial_d   = 1'b0;
          busy_d     = 1'b1;
          state_d    = ST_START;
        end
      end

      ST_START: begin
        if (bit_end) begin
          bit_idx_d = 3'd0;
          serial_d  = data_q[0];
          state_d   = ST_DATA;
        end
      end

      ST_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'(DATA_BITS - 1)) begin
            if (par_en_q) begin
              serial_d = parity;
              state_d  = ST_PARITY;
            end else begin
              serial_d   = 1'b1;
              stop_idx_d = 2'd0;
              state_d    = ST_STOP;
            end
          end else begin
            bit_idx_d = next_idx;
            serial_d  = data_q[next_idx];
          end
        end
      end

      ST_PARITY: begin
        if (bit_end) begin
          serial_d   = 1'b1;
          stop_idx_d = 2'd0;
          state_d    = ST_STOP;
        end
      end

      ST_STOP: begin
        if (bit_end) begin
          if (stop_idx_q == 2'(STOP_BITS - 1)) begin
            serial_d = 1'b1;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            stop_idx_d = stop_idx_q + 2'd1;
          end
        end
      end

      default: begin
        serial_d = 1'b1;
        busy_d   = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      data_q     <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= '0;
      par_en_q   <= 1'b0;
      par_even_q <= 1'b0;
      div_q      <= '0;
      serial_q   <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      par_en_q   <= par_en_d;
      par_even_q <= par_even_d;
      div_q      <= div_d;
      serial_q   <= serial_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tx_if.serial_o = serial_q;
  assign tx_if.busy_o   = busy_q;
  assign tx_if.done_o   = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: expected line waveforms come from a frame-level model
// (start, data LSB first, optional parity, stop, each repeated D times).
module tb_uart_tx;

  logic clk = 1'b0;
  logic rst;

  uart_tx_if ifc();

  uart_tx dut (
    .clock_i (clk),
    .reset_i (rst),
    .tx_if   (ifc)
  );

  always #5 clk = ~clk;

  int   vectors     = 0;
  int   miscompares = 0;
  logic exp_q[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void build_frame(input logic [7:0] b, input bit pe, input bit ev, input int div);
    int   d;
    logic p;
    logic bits[$];
    d = (div == 0) ? 1 : div;
    // even parity: total number of ones including parity is even
    p = (($countones(b) % 2) == 1) ? ev : !ev;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
    if (pe) bits.push_back(p);
    bits.push_back(1'b1);
    exp_q.delete();
    foreach (bits[i]) for (int r = 0; r < d; r++) exp_q.push_back(bits[i]);
  endfunction

  task automatic drive_start(input logic [7:0] b, input bit pe, input bit ev, input logic [15:0] div);
    ifc.data_i          = b;
    ifc.parity_bit_i    = pe;
    ifc.parity_even_i   = ev;
    ifc.clock_divider_i = div;
    ifc.start_i         = 1'b1;
    step();
    ifc.start_i         = 1'b0;
  endtask

  task automatic test_reset();
    rst                 = 1'b1;
    ifc.start_i         = 1'b0;
    ifc.data_i          = 8'h00;
    ifc.parity_bit_i    = 1'b0;
    ifc.parity_even_i   = 1'b0;
    ifc.clock_divider_i = 16'd0;
    #3;
    vectors++;
    if (ifc.serial_o !== 1'b1 || ifc.busy_o !== 1'b0 || ifc.done_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_async got serial=%b busy=%b done=%b want 1 0 0", ifc.serial_o, ifc.busy_o, ifc.done_o);
    end
    step();
    step();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      vectors++;
      if (ifc.serial_o !== 1'b1 || ifc.busy_o !== 1'b0 || ifc.done_o !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_idle k=%0d got serial=%b busy=%b done=%b want 1 0 0", k, ifc.serial_o, ifc.busy_o, ifc.done_o);
      end
    end
  endtask

  task automatic test_basic();
    int k;
    int dones;
    build_frame(8'h55, 1'b0, 1'b0, 2);
    drive_start(8'h55, 1'b0, 1'b0, 16'd2);
    k = 0;
    while (ifc.busy_o === 1'b1 && k < 100) begin
      vectors++;
      if (k >= exp_q.size() || ifc.serial_o !== exp_q[k] || ifc.done_o !== 1'b0) begin
        miscompares++;
        $display("FAIL basic_bit k=%0d got serial=%b done=%b", k, ifc.serial_o, ifc.done_o);
      end
      k++;
      step();
    end
    vectors++;
    if (k !== 20) begin
      miscompares++;
      $display("FAIL basic_busy_len got %0d cycles want 20", k);
    end
    dones = 0;
    for (int j = 0; j < 6; j++) begin
      if (ifc.done_o === 1'b1) dones++;
      if (j == 0) begin
        vectors++;
        if (ifc.done_o !== 1'b1 || ifc.serial_o !== 1'b1) begin
          miscompares++;
          $display("FAIL basic_done got done=%b serial=%b want 1 1", ifc.done_o, ifc.serial_o);
        end
      end
      step();
    end
    vectors++;
    if (dones !== 1) begin
      miscompares++;
      $display("FAIL basic_done_count got %0d want 1", dones);
    end
  endtask

  task automatic test_parity();
    for (int e = 1; e >= 0; e--) begin
      build_frame(8'h07, 1'b1, e[0], 2);
      drive_start(8'h07, 1'b1, e[0], 16'd2);
      for (int k = 0; k < exp_q.size(); k++) begin
        if (k == 18) begin
          vectors++;
          if (ifc.serial_o !== (e[0] ? 1'b1 : 1'b0)) begin
            miscompares++;
            $display("FAIL parity_bit even=%0d got %b want %b", e, ifc.serial_o, e[0]);
          end
        end
        vectors++;
        if (ifc.serial_o !== exp_q[k] || ifc.busy_o !== 1'b1 || ifc.done_o !== 1'b0) begin
          miscompares++;
          $display("FAIL parity_frame k=%0d got serial=%b busy=%b done=%b want serial=%b busy=1 done=0",
                   k, ifc.serial_o, ifc.busy_o, ifc.done_o, exp_q[k]);
        end
        step();
      end
      vectors++;
      if (ifc.done_o !== 1'b1 || ifc.busy_o !== 1'b0 || ifc.serial_o !== 1'b1) begin
        miscompares++;
        $display("FAIL parity_done got done=%b busy=%b serial=%b want 1 0 1", ifc.done_o, ifc.busy_o, ifc.serial_o);
      end
      step();
    end
  endtask

  task automatic test_ignore_start();
    build_frame(8'h55, 1'b0, 1'b0, 2);
    drive_start(8'h55, 1'b0, 1'b0, 16'd2);
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k == 6) begin
        ifc.start_i         = 1'b1;
        ifc.data_i          = 8'hFF;
        ifc.parity_bit_i    = 1'b1;
        ifc.clock_divider_i = 16'd7;
      end
      if (k == 7) ifc.start_i = 1'b0;
      vectors++;
      if (ifc.serial_o !== exp_q[k] || ifc.busy_o !== 1'b1 || ifc.done_o !== 1'b0) begin
        miscompares++;
        $display("FAIL ignore_frame k=%0d got serial=%b busy=%b done=%b want serial=%b busy=1 done=0",
                 k, ifc.serial_o, ifc.busy_o, ifc.done_o, exp_q[k]);
      end
      step();
    end
    vectors++;
    if (ifc.done_o !== 1'b1 || ifc.busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL ignore_done got done=%b busy=%b want 1 0", ifc.done_o, ifc.busy_o);
    end
    for (int k = 0; k < 30; k++) begin
      step();
      vectors++;
      if (ifc.serial_o !== 1'b1 || ifc.busy_o !== 1'b0 || ifc.done_o !== 1'b0) begin
        miscompares++;
        $display("FAIL ignore_no_second k=%0d got serial=%b busy=%b done=%b want 1 0 0", k, ifc.serial_o, ifc.busy_o, ifc.done_o);
      end
    end
  endtask

  task automatic test_reset_mid();
    build_frame(8'h55, 1'b0, 1'b0, 2);
    drive_start(8'h55, 1'b0, 1'b0, 16'd2);
    for (int k = 0; k < 9; k++) begin
      vectors++;
      if (ifc.serial_o !== exp_q[k] || ifc.busy_o !== 1'b1) begin
        miscompares++;
        $display("FAIL rstmid_pre k=%0d got serial=%b busy=%b want serial=%b busy=1", k, ifc.serial_o, ifc.busy_o, exp_q[k]);
      end
      step();
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (ifc.serial_o !== 1'b1 || ifc.busy_o !== 1'b0 || ifc.done_o !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_async got serial=%b busy=%b done=%b want 1 0 0", ifc.serial_o, ifc.busy_o, ifc.done_o);
    end
    step();
    step();
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      vectors++;
      if (ifc.serial_o !== 1'b1 || ifc.busy_o !== 1'b0 || ifc.done_o !== 1'b0) begin
        miscompares++;
        $display("FAIL rstmid_idle k=%0d got serial=%b busy=%b done=%b want 1 0 0", k, ifc.serial_o, ifc.busy_o, ifc.done_o);
      end
    end
  endtask

  task automatic test_divider();
    logic [7:0] b;
    for (int f = 0; f < 3; f++) begin
      b = 8'($urandom);
      if (f == 0) begin
        build_frame(b, 1'b0, 1'b0, 0);
        drive_start(b, 1'b0, 1'b0, 16'd0);
      end else if (f == 1) begin
        build_frame(b, 1'b0, 1'b0, 2);
        drive_start(b, 1'b0, 1'b0, 16'd2);
      end else begin
        // divider input was left at 5 by the previous frame
        build_frame(b, 1'b0, 1'b0, 5);
        ifc.data_i  = b;
        ifc.start_i = 1'b1;
        step();
        ifc.start_i = 1'b0;
      end
      for (int k = 0; k < exp_q.size(); k++) begin
        if (f == 1 && k == 5) ifc.clock_divider_i = 16'd5;
        vectors++;
        if (ifc.serial_o !== exp_q[k] || ifc.busy_o !== 1'b1 || ifc.done_o !== 1'b0) begin
          miscompares++;
          $display("FAIL div_frame f=%0d k=%0d got serial=%b busy=%b done=%b want serial=%b busy=1 done=0",
                   f, k, ifc.serial_o, ifc.busy_o, ifc.done_o, exp_q[k]);
        end
        step();
      end
      vectors++;
      if (ifc.done_o !== 1'b1 || ifc.busy_o !== 1'b0) begin
        miscompares++;
        $display("FAIL div_done f=%0d got done=%b busy=%b want 1 0", f, ifc.done_o, ifc.busy_o);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b0, b1;
    b0 = 8'($urandom);
    b1 = 8'($urandom);
    ifc.data_i          = b0;
    ifc.parity_bit_i    = 1'b1;
    ifc.parity_even_i   = 1'b0;
    ifc.clock_divider_i = 16'd3;
    ifc.start_i         = 1'b1;
    step();
    for (int f = 0; f < 2; f++) begin
      build_frame(f == 0 ? b0 : b1, 1'b1, 1'b0, 3);
      for (int k = 0; k < exp_q.size(); k++) begin
        vectors++;
        if (ifc.serial_o !== exp_q[k] || ifc.busy_o !== 1'b1 || ifc.done_o !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b_frame f=%0d k=%0d got serial=%b busy=%b done=%b want serial=%b busy=1 done=0",
                   f, k, ifc.serial_o, ifc.busy_o, ifc.done_o, exp_q[k]);
        end
        step();
      end
      vectors++;
      if (ifc.done_o !== 1'b1 || ifc.busy_o !== 1'b0 || ifc.serial_o !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_gap f=%0d got done=%b busy=%b serial=%b want 1 0 1", f, ifc.done_o, ifc.busy_o, ifc.serial_o);
      end
      ifc.data_i = b1;
      if (f == 1) ifc.start_i = 1'b0;
      step();
    end
  endtask

  task automatic test_loopback();
    logic [7:0] bytes_in[2];
    logic       line[$];
    logic [7:0] rx_data;
    logic       rx_ready;
    bytes_in[0] = 8'hA5;
    bytes_in[1] = 8'h3C;
    for (int n = 0; n < 2; n++) begin
      line.delete();
      drive_start(bytes_in[n], 1'b1, 1'b1, 16'd2);
      for (int k = 0; k < 22; k++) begin
        if (k % 2 == 1) line.push_back(ifc.serial_o);
        step();
      end
      rx_data = '0;
      for (int i = 0; i < 8; i++) rx_data[i] = line[1 + i];
      rx_ready = (line[0] === 1'b0) && (line[10] === 1'b1) &&
                 ((($countones(rx_data) + int'(line[9])) % 2) == 0);
      vectors++;
      if (rx_data !== bytes_in[n] || rx_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL loopback n=%0d got data=%h ready=%b want data=%h ready=1", n, rx_data, rx_ready, bytes_in[n]);
      end
      step();
      step();
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    bit         pe, ev;
    int         div;
    int         junk;
    for (int f = 0; f < 30; f++) begin
      b    = 8'($urandom);
      pe   = 1'($urandom);
      ev   = 1'($urandom);
      div  = int'($urandom_range(0, 5));
      build_frame(b, pe, ev, div);
      junk = int'($urandom_range(1, exp_q.size() - 2));
      drive_start(b, pe, ev, 16'(div));
      for (int k = 0; k < exp_q.size(); k++) begin
        if (k == junk) begin
          ifc.start_i         = 1'b1;
          ifc.data_i          = 8'($urandom);
          ifc.parity_bit_i    = 1'($urandom);
          ifc.parity_even_i   = 1'($urandom);
          ifc.clock_divider_i = 16'($urandom_range(0, 9));
        end
        if (k == junk + 1) ifc.start_i = 1'b0;
        vectors++;
        if (ifc.serial_o !== exp_q[k] || ifc.busy_o !== 1'b1 || ifc.done_o !== 1'b0) begin
          miscompares++;
          $display("FAIL rand_frame f=%0d k=%0d d=%0d got serial=%b busy=%b done=%b want serial=%b busy=1 done=0",
                   f, k, div, ifc.serial_o, ifc.busy_o, ifc.done_o, exp_q[k]);
        end
        step();
      end
      vectors++;
      if (ifc.done_o !== 1'b1 || ifc.busy_o !== 1'b0 || ifc.serial_o !== 1'b1) begin
        miscompares++;
        $display("FAIL rand_done f=%0d got done=%b busy=%b serial=%b want 1 0 1", f, ifc.done_o, ifc.busy_o, ifc.serial_o);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_ignore_start();
    test_reset_mid();
    test_divider();
    test_back_to_back();
    test_loopback();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
